// File: rtl/ntt_pkg.sv
// Shared constants, stage bundle and FSM encoding for the NTT butterfly engine.
package ntt_pkg;
  localparam int Q      = 3329;
  localparam int N      = 256;
  localparam int CW     = 12;
  localparam int AW     = 8;
  localparam int ZW     = 7;
  localparam int BAR_SH = 24;
  localparam int BAR_M  = (1 << BAR_SH) / Q;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    FIN
  } state_t;

  typedef struct packed {
    logic          v;
    logic [AW-1:0] ia;
    logic [AW-1:0] ib;
    logic [CW-1:0] a;
    logic [CW-1:0] b;
  } bf_stage_t;
endpackage

// File: rtl/ntt_mod_mul.sv
// Pipelined 12x12 modular multiply with Barrett reduction into [0,Q).
module ntt_mod_mul
  import ntt_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  output logic [CW-1:0] r
);
  localparam int PW = 2 * CW;
  localparam int MW = PW + 13;
  localparam int QW = MW - BAR_SH;
  localparam int RW = CW + 1;
  localparam logic [RW-1:0] QX = Q[RW-1:0];

  logic [PW-1:0] p_q;
  logic [MW-1:0] pm;
  logic [QW-1:0] qe;
  logic [RW-1:0] r0;
  logic [CW-1:0] r1;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) p_q <= '0;
    else        p_q <= PW'(a) * PW'(b);

  // quotient estimate is low by at most one, so one subtract finishes it
  assign pm = MW'(p_q) * MW'(BAR_M);
  assign qe = QW'(pm >> BAR_SH);
  assign r0 = RW'(p_q - PW'(qe) * PW'(Q));
  assign r1 = (r0 >= QX) ? CW'(r0 - QX) : CW'(r0);

  if (LAT == 1) begin : g_l1
    assign r = r1;
  end else begin : g_ln
    logic [CW-1:0] dl [LAT-1];
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        for (int i = 0; i < LAT - 1; i++) dl[i] <= '0;
      end else begin
        dl[0] <= r1;
        for (int i = 1; i < LAT - 1; i++) dl[i] <= dl[i-1];
      end
    assign r = dl[LAT-2];
  end
endmodule

// File: rtl/ntt_bf_ctrl.sv
// In-place NTT sequencer + butterfly datapath; NTT_INTT_EN adds inverse layers.
module ntt_bf_ctrl
  import ntt_pkg::*;
#(
  parameter int PIPE_LAT = 3,
  parameter int N_LAYERS = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
`ifdef NTT_INTT_EN
  input  logic          inv,
`endif
  output logic          busy,
  output logic          done,
  output logic [ZW-1:0] zeta_addr,
  input  logic [CW-1:0] zeta,
  output logic [AW-1:0] rd_addr_a,
  output logic [AW-1:0] rd_addr_b,
  input  logic [CW-1:0] rd_data_a,
  input  logic [CW-1:0] rd_data_b,
  output logic          we,
  output logic [AW-1:0] wr_addr_a,
  output logic [AW-1:0] wr_addr_b,
  output logic [CW-1:0] wr_data_a,
  output logic [CW-1:0] wr_data_b
);
  localparam int L = PIPE_LAT - 1;
  localparam logic [CW:0] QX = Q[CW:0];

  function automatic logic [CW-1:0] add_q(
    input logic [CW-1:0] x,
    input logic [CW-1:0] y
  );
    logic [CW:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= QX) s = s - QX;
    return CW'(s);
  endfunction

  function automatic logic [CW-1:0] sub_q(
    input logic [CW-1:0] x,
    input logic [CW-1:0] y
  );
    logic [CW:0] d;
    d = {1'b0, x} + QX - {1'b0, y};
    if (d >= QX) d = d - QX;
    return CW'(d);
  endfunction

  state_t        state;
  logic [AW-1:0] len, len_nxt, j_new;
  logic [AW:0]   base, nb, jp1;
  logic [6:0]    icnt;
  logic [1:0]    dcnt;
  logic [2:0]    lyr;
  logic          last_grp;

`ifdef NTT_INTT_EN
  logic inv_q, inv_s;
  assign inv_s = inv;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                      inv_q <= 1'b0;
    else if (state == IDLE && start) inv_q <= inv;
`else
  logic inv_q, inv_s;
  assign inv_q = 1'b0;
  assign inv_s = 1'b0;
`endif

  assign jp1      = {1'b0, rd_addr_a} + 9'd1;
  assign nb       = base + {len, 1'b0};
  assign j_new    = nb[AW-1:0];
  assign last_grp = (jp1 == base + {1'b0, len});
  assign len_nxt  = inv_q ? {len[AW-2:0], 1'b0}
                          : {1'b0, len[AW-1:1]};

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      len       <= '0;
      base      <= '0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      zeta_addr <= '0;
      icnt      <= '0;
      dcnt      <= '0;
      lyr       <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          state     <= ISSUE;
          busy      <= 1'b1;
          len       <= inv_s ? 8'd2 : 8'd128;
          base      <= '0;
          rd_addr_a <= '0;
          rd_addr_b <= inv_s ? 8'd2 : 8'd128;
          zeta_addr <= inv_s ? 7'd127 : 7'd1;
          icnt      <= '0;
          lyr       <= '0;
        end
        ISSUE: begin
          icnt <= icnt + 7'd1;
          if (last_grp) begin
            base      <= nb;
            rd_addr_a <= j_new;
            rd_addr_b <= j_new + len;
            zeta_addr <= inv_q ? zeta_addr - 7'd1
                               : zeta_addr + 7'd1;
          end else begin
            rd_addr_a <= rd_addr_a + 8'd1;
            rd_addr_b <= rd_addr_b + 8'd1;
          end
          if (icnt == 7'd127) begin
            state <= DRAIN;
            dcnt  <= '0;
          end
        end
        DRAIN: begin
          dcnt <= dcnt + 2'd1;
          if (dcnt == 2'(L)) begin
            if (lyr == 3'(N_LAYERS - 1)) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state     <= ISSUE;
              lyr       <= lyr + 3'd1;
              len       <= len_nxt;
              base      <= '0;
              rd_addr_a <= '0;
              rd_addr_b <= len_nxt;
              icnt      <= '0;
            end
          end
        end
        FIN: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end

  // inverse multiplies the difference, so it is formed before the multiplier
  logic [CW-1:0] mm_b, t, res_a, res_b;
  assign mm_b = inv_q ? sub_q(rd_data_b, rd_data_a) : rd_data_b;

  ntt_mod_mul #(.LAT(L)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (zeta),
    .b     (mm_b),
    .r     (t)
  );

  bf_stage_t pipe [L];
  bf_stage_t tl;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < L; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= '{v: (state == ISSUE), ia: rd_addr_a, ib: rd_addr_b,
                   a: rd_data_a, b: rd_data_b};
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end

  assign tl    = pipe[L-1];
  assign res_a = inv_q ? add_q(tl.a, tl.b) : add_q(tl.a, t);
  assign res_b = inv_q ? t : sub_q(tl.a, t);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      we        <= 1'b0;
      wr_addr_a <= '0;
      wr_addr_b <= '0;
      wr_data_a <= '0;
      wr_data_b <= '0;
    end else begin
      we        <= tl.v;
      wr_addr_a <= tl.ia;
      wr_addr_b <= tl.ib;
      wr_data_a <= res_a;
      wr_data_b <= res_b;
    end
endmodule

// File: tb/tb_ntt_bf_ctrl.sv
// Bench for ntt_bf_ctrl: register file and zeta ROM models, golden NTT,
// write-trace and timing checks under random coefficient vectors.
module tb_ntt_bf_ctrl;
  localparam int Q = 3329;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, we;
  logic [6:0]  zeta_addr;
  logic [11:0] zeta, rd_data_a, rd_data_b, wr_data_a, wr_data_b;
  logic [7:0]  rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
`ifdef NTT_INTT_EN
  logic        inv = 1'b0;
`endif

  logic [11:0] mem  [256];
  logic [11:0] init [256];
  logic        load = 1'b0;
  int          zt   [128];
  int          gold [256];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  ntt_bf_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
`ifdef NTT_INTT_EN
    .inv       (inv),
`endif
    .busy      (busy),
    .done      (done),
    .zeta_addr (zeta_addr),
    .zeta      (zeta),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .we        (we),
    .wr_addr_a (wr_addr_a),
    .wr_addr_b (wr_addr_b),
    .wr_data_a (wr_data_a),
    .wr_data_b (wr_data_b)
  );

  assign rd_data_a = mem[rd_addr_a];
  assign rd_data_b = mem[rd_addr_b];
  assign zeta      = 12'(zt[zeta_addr]);

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 256; i++) mem[i] <= init[i];
    end else if (we) begin
      mem[wr_addr_a] <= wr_data_a;
      mem[wr_addr_b] <= wr_data_b;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  function automatic int brv7(input int x);
    int r;
    r = 0;
    for (int b = 0; b < 7; b++) r = (r << 1) | ((x >> b) & 1);
    return r;
  endfunction

  function automatic int powq(input int e);
    longint r;
    r = 1;
    for (int i = 0; i < e; i++) r = (r * 17) % Q;
    return int'(r);
  endfunction

  task automatic ntt_ref();
    int k, t, z;
    k = 1;
    for (int i = 0; i < 256; i++) gold[i] = int'(init[i]);
    for (int len = 128; len >= 2; len = len / 2)
      for (int s = 0; s < 256; s += 2 * len) begin
        z = zt[k];
        k++;
        for (int j = s; j < s + len; j++) begin
          t = (z * gold[j+len]) % Q;
          gold[j+len] = (gold[j] - t + Q) % Q;
          gold[j]     = (gold[j] + t) % Q;
        end
      end
  endtask

  // mode 0: plain run, 1: stray starts at cycles 5/300, 2: reset at cycle 400
  task automatic run(input int mode, input string nm);
    int busy_n, done_at, done_n, wcnt, dup, perr, big, p;
    bit seen [256];
    busy_n = 0; done_at = 0; done_n = 0;
    wcnt = 0; dup = 0; perr = 0; big = 0;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    ntt_ref();
    start = 1'b1;
    for (int i = 1; i <= 1200 && (done_at == 0 || i <= done_at + 4); i++) begin
      @(negedge clk);
      start = (mode == 1 && (i == 5 || i == 300));
      if (mode == 2 && i == 400) begin
        #2 rst_n = 1'b0;
        #1;
        chk({nm, " async we"}, int'(we), 0);
        chk({nm, " async busy"}, int'(busy), 0);
        chk({nm, " async done"}, int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk({nm, " idle after reset"}, int'(busy), 0);
        return;
      end
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_at == 0) done_at = i;
      end
      if (i <= 128 && (zeta_addr != 7'd1 || int'(rd_addr_a) != i - 1 ||
                       int'(rd_addr_b) != i + 127))
        perr++;
      if (we) begin
        p = wcnt % 128;
        if (p == 0) for (int a = 0; a < 256; a++) seen[a] = 1'b0;
        if (seen[wr_addr_a] || seen[wr_addr_b] || wr_addr_a == wr_addr_b) dup++;
        seen[wr_addr_a] = 1'b1;
        seen[wr_addr_b] = 1'b1;
        if (wcnt < 128 && (int'(wr_addr_a) != wcnt ||
                           int'(wr_addr_b) != wcnt + 128))
          perr++;
        if (int'(wr_data_a) >= Q || int'(wr_data_b) >= Q) big++;
        wcnt++;
      end
    end
    chk({nm, " done cycle"}, done_at, 918);
    chk({nm, " done pulses"}, done_n, 1);
    chk({nm, " busy cycles"}, busy_n, 918);
    chk({nm, " write cycles"}, wcnt, 896);
    chk({nm, " dup addr"}, dup, 0);
    chk({nm, " layer1 pairs"}, perr, 0);
    chk({nm, " out of range"}, big, 0);
    for (int a = 0; a < 256; a++)
      chk($sformatf("%s mem[%0d]", nm, a), int'(mem[a]), gold[a]);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 256; i++) init[i] = 12'($urandom_range(0, Q - 1));
  endtask

  initial begin
    for (int i = 0; i < 128; i++) zt[i] = powq(brv7(i));
    for (int i = 0; i < 256; i++) init[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst we", int'(we), 0);
    chk("rst rd_addr_a", int'(rd_addr_a), 0);
    chk("rst rd_addr_b", int'(rd_addr_b), 0);
    chk("rst zeta_addr", int'(zeta_addr), 0);
    chk("rst wr_addr_b", int'(wr_addr_b), 0);
    chk("rst wr_data_a", int'(wr_data_a), 0);
    rst_n = 1'b1;
    @(negedge clk);

    run(0, "zero");
    init[0] = 12'd1;
    run(0, "delta");
    fill_rand();
    run(0, "rand1");
    fill_rand();
    run(0, "rand2");
    for (int i = 0; i < 256; i++) init[i] = 12'(Q - 1);
    run(0, "max");
    fill_rand();
    run(1, "spur");
    run(0, "again");
    fill_rand();
    run(2, "rst");
    fill_rand();
    run(0, "post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ntt_bf_ctrl.md
Name: ntt_bf_ctrl

Overview:
- Forward-NTT engine for 256 x 12-bit coefficients, Kyber modulus q = 3329.
- Drives the dual-port coefficient register file: two combinational reads per cycle, two writes per cycle under one write enable.
- Sequences the 7 Cooley-Tukey layers (len = 128 down to 2), computes one butterfly per cycle through a fixed-latency pipeline, and writes results back in place.
- Sits directly upstream of the register file; the zeta ROM sits beside it.

Parameters:
- Q, 3329, modulus.
- PIPE_LAT, 3, butterfly pipeline depth in cycles, from read to write. Legal values 2..4.
- N_LAYERS, 7, number of NTT layers.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a transform when idle.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse after the final write.
- zeta_addr  out  7  zeta ROM index k.
- zeta  in  12  zeta ROM data; combinational on zeta_addr.
- rd_addr_a  out  8  read address j, to register file port A.
- rd_addr_b  out  8  read address j+len, to register file port B.
- rd_data_a  in  12  combinational read data, port A.
- rd_data_b  in  12  combinational read data, port B.
- we  out  1  write enable, common to both write ports.
- wr_addr_a  out  8  write address, port A.
- wr_addr_b  out  8  write address, port B.
- wr_data_a  out  12  a' result.
- wr_data_b  out  12  b' result.

Behaviour:
- Reset values: busy, done and we are 0. All address, data and zeta_addr outputs are 0. FSM is in IDLE.
- States:
  - IDLE: start=1 -> ISSUE; latch len=128, start=0, j=0, k=1. start while busy is ignored.
  - ISSUE: each cycle presents j and j+len on the read ports and k on zeta_addr.
    - Captures rd_data_a, rd_data_b and zeta into pipeline stage 1.
    - j increments. When j+1 == start+len: start += 2*len, j = new start, k++.
    - After the 128th issue of the layer -> DRAIN.
  - DRAIN: waits PIPE_LAT cycles so that all writes of the layer land before the next layer reads.
    - If len == 2 -> FIN.
    - Else len >>= 1, start = 0, j = 0 -> ISSUE. k continues; it is not reset.
  - FIN: done=1 for one cycle, busy drops in the same cycle -> IDLE.
- Butterfly:
  - t = (zeta*b) mod Q, with the 24-bit product fully reduced to [0,Q).
  - a' = a+t, minus Q if the sum is >= Q.
  - b' = a-t, plus Q if the difference is negative.
  - Inputs are in [0,Q). Outputs are always in [0,Q).
- Write timing: we is high exactly PIPE_LAT cycles after each ISSUE cycle. Write addresses are the pipelined read addresses.
- No intra-layer hazard: each index is touched once per layer.
- Timing: start-to-done = N_LAYERS*(128+PIPE_LAT)+1 cycles; 918 for the defaults. busy is high for that many cycles.
- Reset mid-operation: asynchronous return to IDLE; we drops immediately and the pipeline is flushed. Register file contents are undefined (partial transform).
- Address wrap: j+len never exceeds 255 by construction; the 8-bit adders need no wrap handling.

Optional Feature:
- Macro: NTT_INTT_EN.
- Defined:
  - Adds input port inv (1 bit), sampled at start.
  - inv=1 runs Gentleman-Sande inverse layers: len = 2 up to 128, k starts at 127 and decrements.
  - Inverse butterfly: a' = (a+b) mod Q, b' = zeta*(b-a) mod Q.
  - Final n^-1 scaling is out of scope.
- Undefined: inv port absent; forward only. Behaviour is identical to the above.

Decomposition:
- Package ntt_pkg holds:
  - Q, N=256, coefficient width 12, address width 8, zeta index width 7.
  - The Barrett constant for Q.
  - The FSM state encoding IDLE/ISSUE/DRAIN/FIN.
- Sub-module ntt_mod_mul: pipelined 12x12 multiply plus Barrett reduction to [0,Q), latency PIPE_LAT-1.
- Add/subtract correction stays in ntt_bf_ctrl.

Test Plan:
- All-zero memory, start -> all 256 entries remain 0; done pulses at cycle 918; busy is high for 918 cycles.
- Delta input mem[0]=1, others 0 -> all 256 entries equal 1 after done.
- Random vectors in [0,3328], including all-3328 -> memory matches a golden software NTT bit-exactly; no write value >= 3329.
- Write trace -> exactly 896 cycles with we=1, 128 per layer. No write address repeats within a layer. First layer pairs are (0,128)...(127,255) with zeta_addr=1.
- start pulses at cycles 5 and 300 of a run -> ignored; a single done pulse. A second start after done produces an identical result.
- rst_n asserted at cycle 400 -> we=0, busy=0 and done=0 asynchronously. A subsequent start runs a full 918-cycle transform.
